uart_bus_loader: RTL

UART_BUS_LOADER -- requirements
Module: uart_bus_loader

---
 rtl/uart_bus_loader.sv | 291 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_bus_loader.sv
// uart_bus_loader
//   Receives a length-prefixed word stream over a UART (8N1, LSB first) and
//   writes it to a word-addressed bus starting at BASE.
//   Stream format: N as 4 bytes little-endian, then N words of 4 bytes each,
//   also little-endian.
//
// Parameters
//   WIDTH   bus data/address width
//   DEPTH   largest accepted word count N
//   CLKRATE clk frequency in Hz
//   BAUD    UART bit rate (CPB = CLKRATE/BAUD clocks per bit)
//   BASE    bus address of the first word written
//
// Ports
//   clk        clock, all state on its rising edge
//   nrst       asynchronous active-low reset
//   rx         UART serial input (asynchronous, idle high)
//   start      one-cycle pulse arming a load (ignored while busy)
//   enw        bus write enable, one cycle per word
//   address    bus word address (0 outside WRITE/VERIFY)
//   wdata      bus write data (0 outside WRITE/VERIFY)
//   rdata      bus read data, valid one cycle after address with enw=0
//   busy       load in progress
//   done       last load completed, held until next accepted start
//   error      sticky fault flag, cleared by accepted start
//   word_count words written in the current/last load
//
// Build option
//   LOADER_READBACK_EN : read every written word back and compare it;
//                        a mismatch aborts the load with error set.

module uart_bus_loader #(
    parameter int unsigned       WIDTH   = 32,
    parameter int unsigned       DEPTH   = 100_000,
    parameter int unsigned       CLKRATE = 25000000,
    parameter int unsigned       BAUD    = 115200,
    parameter logic [WIDTH-1:0]  BASE    = '0
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             rx,
    input  logic             start,
    output logic             enw,
    output logic [WIDTH-1:0] address,
    output logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] rdata,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] word_count
);

    localparam int unsigned CPB  = CLKRATE / BAUD;
    localparam int unsigned HALF = CPB / 2;
    localparam int unsigned CW   = $clog2(CPB + 1);

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_BITS,
        RX_STOP
    } rx_state_t;

    rx_state_t       rx_state, rx_state_n;
    logic            rx_meta, rx_sync, rx_prev;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_nbit;
    logic [7:0]      rx_shift;
    logic            tick_half, tick_full;
    logic            byte_valid, frame_err;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        tick_half  = (rx_cnt == CW'(HALF - 1));
        tick_full  = (rx_cnt == CW'(CPB - 1));
        case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_sync) rx_state_n = RX_START;
            // Line back high at mid start bit: a glitch, not a byte.
            RX_START: if (tick_half) rx_state_n = rx_sync ? RX_IDLE : RX_BITS;
            RX_BITS:  if (tick_full && rx_nbit == 3'd7) rx_state_n = RX_STOP;
            RX_STOP:  if (tick_full) rx_state_n = RX_IDLE;
            default:  rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_nbit    <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_state <= rx_state_n;
            // Counter restarts at each state change and at every bit boundary.
            if (rx_state == RX_IDLE || rx_state_n != rx_state || tick_full)
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + CW'(1);
            if (rx_state == RX_IDLE)
                rx_nbit <= '0;
            else if (rx_state == RX_BITS && tick_full) begin
                rx_shift <= {rx_sync, rx_shift[7:1]};
                rx_nbit  <= rx_nbit + 3'd1;
            end
            byte_valid <= (rx_state == RX_STOP) && tick_full && rx_sync;
            frame_err  <= (rx_state == RX_STOP) && tick_full && !rx_sync;
        end
    end

    // ------------------------------------------------------------------
    // Load controller
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
`ifdef LOADER_READBACK_EN
        S_VERIFY,
`endif
        S_DONE
    } state_t;

    state_t           state, state_n;
    logic [1:0]       bcnt;
    logic [31:0]      asm_q, asm_next;
    logic [WIDTH-1:0] len, word, wc_next;
    logic             byte_last, accept, fin_ok, fin_err;

    assign asm_next  = {rx_shift, asm_q[31:8]};
    assign byte_last = byte_valid && (bcnt == 2'd3);
    assign wc_next   = word_count + WIDTH'(1);

`ifdef LOADER_READBACK_EN
    logic vcnt;
`else
    logic rdata_unused;
    assign rdata_unused = ^rdata;
`endif

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        fin_ok  = 1'b0;
        fin_err = 1'b0;
        case (state)
            // DONE lasts one cycle and behaves as IDLE so a start is taken.
            S_IDLE, S_DONE: begin
                state_n = S_IDLE;
                if (start) begin
                    state_n = S_LEN;
                    accept  = 1'b1;
                end
            end
            S_LEN: begin
                if (frame_err) begin
                    state_n = S_IDLE;
                    fin_err = 1'b1;
                end else if (byte_last) begin
                    if (asm_next == '0) begin
                        state_n = S_DONE;
                        fin_ok  = 1'b1;
                    end else if (asm_next > DEPTH) begin
                        state_n = S_IDLE;
                        fin_err = 1'b1;
                    end else begin
                        state_n = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (frame_err) begin
                    state_n = S_IDLE;
                    fin_err = 1'b1;
                end else if (byte_last) begin
                    state_n = S_WRITE;
                end
            end
            S_WRITE: begin
`ifdef LOADER_READBACK_EN
                state_n = S_VERIFY;
`else
                if (wc_next == len) begin
                    state_n = S_DONE;
                    fin_ok  = 1'b1;
                end else begin
                    state_n = S_DATA;
                end
`endif
            end
`ifdef LOADER_READBACK_EN
            S_VERIFY: begin
                // word_count already counts the word under test.
                if (vcnt) begin
                    if (rdata != word) begin
                        state_n = S_IDLE;
                        fin_err = 1'b1;
                    end else if (word_count == len) begin
                        state_n = S_DONE;
                        fin_ok  = 1'b1;
                    end else begin
                        state_n = S_DATA;
                    end
                end
            end
`endif
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        enw     = 1'b0;
        address = '0;
        wdata   = '0;
        if (state == S_WRITE) begin
            enw     = 1'b1;
            address = BASE + word_count;
            wdata   = word;
        end
`ifdef LOADER_READBACK_EN
        if (state == S_VERIFY)
            address = BASE + word_count - WIDTH'(1);
`endif
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= S_IDLE;
            bcnt       <= '0;
            asm_q      <= '0;
            len        <= '0;
            word       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
`ifdef LOADER_READBACK_EN
            vcnt       <= 1'b0;
`endif
        end else begin
            state <= state_n;
            if (accept) begin
                busy       <= 1'b1;
                done       <= 1'b0;
                error      <= 1'b0;
                word_count <= '0;
                bcnt       <= '0;
            end else begin
                if (fin_ok) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                if (fin_err) begin
                    busy  <= 1'b0;
                    error <= 1'b1;
                end
                if (state == S_WRITE)
                    word_count <= wc_next;
                if ((state == S_LEN || state == S_DATA) && byte_valid) begin
                    bcnt  <= bcnt + 2'd1;
                    asm_q <= asm_next;
                end
            end
            if (state == S_LEN && byte_last)
                len <= WIDTH'(asm_next);
            if (state == S_DATA && byte_last)
                word <= WIDTH'(asm_next);
`ifdef LOADER_READBACK_EN
            vcnt <= (state == S_VERIFY);
`endif
        end
    end

endmodule
